// File: rtl/fft_out_streamer.sv
// fft_out_streamer: streams FFT result SRAMs out in natural bin order
// through a 2-entry valid/ready buffer.
module fft_out_streamer #(
   parameter int N       = 2048,
   parameter int ADDR_W  = 11,
   parameter int DATA_W  = 41,
   parameter int BIT_REV = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic                     mem_rd_en,
   output logic [ADDR_W-1:0]        mem_addr,
   input  logic [DATA_W-1:0]        mem_rd_r,
   input  logic [DATA_W-1:0]        mem_rd_i,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out_r,
   output logic signed [DATA_W-1:0] out_i,
   output logic [ADDR_W-1:0]        out_index,
   output logic                     out_last
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   typedef struct packed {
      logic [DATA_W-1:0] r;
      logic [DATA_W-1:0] i;
      logic [ADDR_W-1:0] k;
   } ent_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] k_q, k_d, pend_k_q, rev;
   logic              pend_q, done_q, done_d, hs;
   logic [1:0]        cnt_q, cnt_d;
   ent_t              b0_q, b0_d, b1_q, b1_d, ent;

   assign out_valid = cnt_q != 2'd0;
   assign out_r     = b0_q.r;
   assign out_i     = b0_q.i;
   assign out_index = b0_q.k;
   assign out_last  = out_valid && b0_q.k == ADDR_W'(N - 1);
   assign busy      = state_q != IDLE;
   assign done      = done_q;

   always_comb begin
      for (int b = 0; b < ADDR_W; b++) rev[b] = k_q[ADDR_W-1-b];
      mem_addr = (BIT_REV != 0) ? rev : k_q;
   end

   // cnt_d is the buffer occupancy after this edge; a read is only issued
   // if its data will still find a free slot when it returns.
   always_comb begin
      hs        = out_valid && out_ready;
      cnt_d     = cnt_q + {1'b0, pend_q} - {1'b0, hs};
      mem_rd_en = state_q == RUN && cnt_d < 2'd2;
      done_d    = hs && out_last;
      ent       = '{r: mem_rd_r, i: mem_rd_i, k: pend_k_q};
      b0_d      = (pend_q && (cnt_q == 2'd0 || (cnt_q == 2'd1 && hs))) ? ent : hs ? b1_q : b0_q;
      b1_d      = (pend_q && cnt_q == 2'd1 && !hs) ? ent : b1_q;
      state_d   = state_q;
      k_d       = k_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = RUN;
            k_d     = '0;
         end
         RUN: if (mem_rd_en) begin
            k_d = k_q + 1'b1;
            if (k_q == ADDR_W'(N - 1)) state_d = DRAIN;
         end
         DRAIN: if (done_d) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         k_q      <= '0;
         pend_q   <= 1'b0;
         pend_k_q <= '0;
         cnt_q    <= '0;
         b0_q     <= '0;
         b1_q     <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         pend_q   <= mem_rd_en;
         pend_k_q <= mem_rd_en ? k_q : pend_k_q;
         cnt_q    <= cnt_d;
         b0_q     <= b0_d;
         b1_q     <= b1_d;
         done_q   <= done_d;
      end
   end
endmodule

// File: tb/tb_fft_out_streamer.sv
// tb_fft_out_streamer: scoreboard bench for both BIT_REV settings of fft_out_streamer.
module tb_fft_out_streamer;
   localparam int N = 2048, AW = 11, DW = 41;
   localparam logic [DW-1:0] POS = 41'h0FFFFFFFFFF;
   localparam logic [DW-1:0] NEG = 41'h10000000000;

   typedef struct {
      logic [DW-1:0] r;
      logic [DW-1:0] i;
      logic [AW-1:0] k;
   } exp_t;

   logic clk = 0, rst = 1, start = 0, out_ready = 0, sel = 0;
   int   checks = 0, errors = 0, mode = 0;
   exp_t q[$];

   logic          busy1, done1, rd1, valid1, last1, busy0, done0, rd0, valid0, last0;
   logic [AW-1:0] addr1, idx1, addr0, idx0;
   logic [DW-1:0] mr1, mi1, or1, oi1, mr0, mi0, or0, oi0;
   logic          busy, done, rd, valid, last;
   logic [AW-1:0] addr, idx;
   logic [DW-1:0] o_r, o_i;

   always #5 clk = ~clk;

   fft_out_streamer #(.N(N), .ADDR_W(AW), .DATA_W(DW), .BIT_REV(1)) dut (
      .clk(clk), .rst(rst), .start(start & ~sel), .busy(busy1), .done(done1),
      .mem_rd_en(rd1), .mem_addr(addr1), .mem_rd_r(mr1), .mem_rd_i(mi1),
      .out_valid(valid1), .out_ready(out_ready), .out_r(or1), .out_i(oi1),
      .out_index(idx1), .out_last(last1));

   fft_out_streamer #(.N(N), .ADDR_W(AW), .DATA_W(DW), .BIT_REV(0)) dut_nat (
      .clk(clk), .rst(rst), .start(start & sel), .busy(busy0), .done(done0),
      .mem_rd_en(rd0), .mem_addr(addr0), .mem_rd_r(mr0), .mem_rd_i(mi0),
      .out_valid(valid0), .out_ready(out_ready), .out_r(or0), .out_i(oi0),
      .out_index(idx0), .out_last(last0));

   assign busy  = sel ? busy0  : busy1;
   assign done  = sel ? done0  : done1;
   assign rd    = sel ? rd0    : rd1;
   assign valid = sel ? valid0 : valid1;
   assign last  = sel ? last0  : last1;
   assign addr  = sel ? addr0  : addr1;
   assign idx   = sel ? idx0   : idx1;
   assign o_r   = sel ? or0    : or1;
   assign o_i   = sel ? oi0    : oi1;

   function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
      logic [AW-1:0] v;
      for (int b = 0; b < AW; b++) v[b] = a[AW-1-b];
      return v;
   endfunction

   function automatic logic [DW-1:0] mem_re(input int m, input logic [AW-1:0] a);
      return m == 0 ? DW'(a) : a[0] ? NEG : POS;
   endfunction

   function automatic logic [DW-1:0] mem_im(input int m, input logic [AW-1:0] a);
      return m == 0 ? DW'(0) - DW'(a) : a[0] ? POS : NEG;
   endfunction

   always @(posedge clk) begin
      if (rd1) begin
         mr1 <= mem_re(mode, addr1);
         mi1 <= mem_im(mode, addr1);
      end
      if (rd0) begin
         mr0 <= mem_re(mode, addr0);
         mi0 <= mem_im(mode, addr0);
      end
   end

   task automatic run_stream(input int rpct, input bit stall, input int start_at, input int abort_at);
      exp_t          e;
      int            c = 0, iss = 0, hsn = 0, first = -1;
      bit            pv = 0, done_exp = 0, fin = 0, hs;
      logic [DW-1:0] hr, hi;
      logic [AW-1:0] hk;
      logic          hl;
      for (int k = 0; k < N; k++) begin
         e.k = AW'(k);
         e.r = mem_re(mode, sel ? AW'(k) : bitrev(AW'(k)));
         e.i = mem_im(mode, sel ? AW'(k) : bitrev(AW'(k)));
         q.push_back(e);
      end
      start = 1;
      @(posedge clk);
      while (!fin && c < 20000) begin
         @(negedge clk);
         start = start_at >= 0 && hsn == start_at;
         out_ready = (stall && c >= 2 && c < 22) ? 1'b0 : ($urandom_range(99) < rpct);
         #1;
         hs = valid && out_ready;
         if (c == 0) begin
            checks++;
            if ({rd, addr} !== {1'b1, AW'(0)}) begin
               errors++;
               $display("FAIL first_read: rd=%b addr=%0d want rd=1 addr=0", rd, addr);
            end
         end
         if (valid && first < 0) begin
            first = c;
            checks++;
            if (c !== 2) begin
               errors++;
               $display("FAIL latency: first valid at cycle %0d want 2", c);
            end
         end
         if (pv) begin
            checks++;
            if ({valid, o_r, o_i, idx, last} !== {1'b1, hr, hi, hk, hl}) begin
               errors++;
               $display("FAIL stall_hold: got v=%b k=%0d r=%h i=%h want k=%0d r=%h i=%h", valid, idx, o_r, o_i, hk, hr, hi);
            end
         end
         if (stall && c >= 2 && c < 22) begin
            checks++;
            if (rd !== 1'b0 || idx !== AW'(0)) begin
               errors++;
               $display("FAIL stall_reads: rd=%b idx=%0d want rd=0 idx=0 at cycle %0d", rd, idx, c);
            end
         end
         if (rpct == 100 && !stall && c >= 2 && hsn < N) begin
            checks++;
            if (valid !== 1'b1) begin
               errors++;
               $display("FAIL throughput: valid=%b want 1 at cycle %0d", valid, c);
            end
         end
         if (rd) iss++;
         checks++;
         if (iss - hsn - int'(hs) > 2) begin
            errors++;
            $display("FAIL outstanding: got %0d want <=2", iss - hsn - int'(hs));
         end
         checks++;
         if (done_exp) begin
            if ({done, busy} !== 2'b10 || q.size() != 0) begin
               errors++;
               $display("FAIL done: done=%b busy=%b left=%0d want done=1 busy=0 left=0", done, busy, q.size());
            end
            fin = 1;
         end else if (done !== 1'b0) begin
            errors++;
            $display("FAIL early_done: done=%b want 0 after %0d samples", done, hsn);
         end
         if (hs && !fin) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL extra_sample: got k=%0d want none", idx);
            end else begin
               e = q.pop_front();
               if ({o_r, o_i, idx, last} !== {e.r, e.i, e.k, e.k == AW'(N - 1)}) begin
                  errors++;
                  $display("FAIL sample: got k=%0d r=%h i=%h last=%b want k=%0d r=%h i=%h last=%b",
                           idx, o_r, o_i, last, e.k, e.r, e.i, e.k == AW'(N - 1));
               end
               done_exp = e.k == AW'(N - 1);
            end
            hsn++;
         end
         pv = valid && !out_ready;
         {hr, hi, hk, hl} = {o_r, o_i, idx, last};
         if (abort_at >= 0 && hs && hsn == abort_at) begin
            rst = 1;
            #1;
            checks++;
            if ({busy, done, rd, addr, valid, last, o_r, o_i, idx} !== '0) begin
               errors++;
               $display("FAIL abort_zero: busy=%b done=%b rd=%b addr=%0d v=%b last=%b r=%h i=%h k=%0d want all 0",
                        busy, done, rd, addr, valid, last, o_r, o_i, idx);
            end
            @(negedge clk);
            rst = 0;
            repeat (5) begin
               @(negedge clk);
               checks++;
               if (done !== 1'b0 || busy !== 1'b0) begin
                  errors++;
                  $display("FAIL abort_done: done=%b busy=%b want 0 0", done, busy);
               end
            end
            q.delete();
            fin = 1;
         end
         c++;
      end
      start = 0;
      if (!fin) begin
         checks++;
         errors++;
         $display("FAIL timeout: %0d samples after %0d cycles want %0d", hsn, c, N);
      end
   endtask

   task automatic test_reset();
      rst = 1;
      repeat (3) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         checks++;
         if ({busy, done, rd, addr, valid, last, o_r, o_i, idx} !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b rd=%b addr=%0d v=%b r=%h k=%0d want all 0",
                     busy, done, rd, addr, valid, o_r, idx);
         end
      end
      sel = 0;
      @(negedge clk);
      rst = 0;
   endtask

   task automatic test_bitrev_stream();
      sel = 0; mode = 0;
      run_stream(100, 0, -1, -1);
   endtask

   task automatic test_natural_order();
      sel = 1; mode = 0;
      run_stream(100, 0, -1, -1);
   endtask

   task automatic test_random_ready();
      sel = 0; mode = 0;
      run_stream(50, 0, -1, -1);
   endtask

   task automatic test_back_to_back_stall();
      run_stream(100, 1, -1, -1);
   endtask

   task automatic test_start_ignored_abort();
      run_stream(100, 0, 100, 500);
      run_stream(100, 0, -1, -1);
   endtask

   task automatic test_extreme();
      mode = 1;
      run_stream(100, 0, -1, -1);
   endtask

   initial begin
      test_reset();
      test_bitrev_stream();
      test_natural_order();
      test_random_ready();
      test_back_to_back_stall();
      test_start_ignored_abort();
      test_extreme();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fft_out_streamer.md
FFT_OUT_STREAMER -- requirements
Module: fft_out_streamer

Interface
REQ-001 Parameter: N, default 2048, transform length (power of two).
REQ-002 Parameter: ADDR_W, default 11, log2(N).
REQ-003 Parameter: DATA_W, default 41, signed result width per component.
REQ-004 Parameter: BIT_REV, default 1, 1 = result SRAM holds bit-reversed order and must be unscrambled.
REQ-005 Port: clk  in  1  single clock, all state on rising edge.
REQ-006 Port: rst  in  1  asynchronous, active-high reset.
REQ-007 Port: start  in  1  one-cycle request to stream the result SRAM out.
REQ-008 Port: busy  out  1  high from accepted start until done.
REQ-009 Port: done  out  1  one-cycle pulse after last output handshake.
REQ-010 Port: mem_rd_en  out  1  read strobe to the real and imaginary result SRAMs.
REQ-011 Port: mem_addr  out  ADDR_W  shared read address.
REQ-012 Port: mem_rd_r  in  DATA_W  real read data, valid the cycle after mem_rd_en.
REQ-013 Port: mem_rd_i  in  DATA_W  imaginary read data, same timing.
REQ-014 Port: out_valid  out  1  output sample available.
REQ-015 Port: out_ready  in  1  downstream accepts the sample.
REQ-016 Port: out_r  out  DATA_W  real part, signed.
REQ-017 Port: out_i  out  DATA_W  imaginary part, signed.
REQ-018 Port: out_index  out  ADDR_W  natural-order bin index k of the current sample.
REQ-019 Port: out_last  out  1  high with the sample where out_index = N-1.

Function
REQ-020 The block SHALL be an FSM with states IDLE, RUN (issuing reads), DRAIN (all N reads issued, buffered data outstanding), returning to IDLE.
REQ-021 IDLE->RUN on start=1; start while busy=1 SHALL be ignored.
REQ-022 Issue counter k runs 0..N-1; mem_addr SHALL be bit-reverse(k) over ADDR_W bits when BIT_REV=1, else k.
REQ-023 A read SHALL be issued (mem_rd_en=1) only when in-flight reads plus buffered samples < 2; the output buffer is 2 entries deep so no read data is ever dropped.
REQ-024 Read data SHALL be captured into the buffer the cycle after mem_rd_en, tagged with its k.
REQ-025 A handshake occurs when out_valid and out_ready are both high at a rising edge; the head entry is then retired.
REQ-026 While out_valid=1 and out_ready=0, out_r, out_i, out_index, out_last SHALL hold stable.
REQ-027 Latency: with start sampled at edge E0, mem_rd_en/addr for k=0 SHALL be driven after E0, out_valid SHALL rise after E2.
REQ-028 With out_ready held high, throughput SHALL be one sample per cycle, N consecutive valid cycles.
REQ-029 RUN->DRAIN when read k=N-1 is issued; DRAIN->IDLE on handshake of out_last sample; done pulses during the cycle after that edge, busy falls in the same cycle.
REQ-030 Data SHALL pass unmodified (no scaling, no sign change); out_index SHALL always be natural order.
REQ-031 start coincident with done cycle SHALL be accepted (state is IDLE then).

Reset
REQ-032 rst=1 SHALL asynchronously force IDLE, k=0, buffer empty, busy=0, done=0, mem_rd_en=0, mem_addr=0, out_valid=0, out_last=0, out_r=0, out_i=0, out_index=0.
REQ-033 Reset mid-stream SHALL abort the transfer; no done pulse; next start restarts at k=0.

Verification
REQ-034 SRAM preloaded mem[a]=a (real), -a (imag), BIT_REV=1, out_ready=1, start pulse -> 2048 consecutive samples, out_index=k, out_r=bitrev11(k), out_i=-bitrev11(k); first out_valid after E2; done 1 cycle after k=2047.
REQ-035 BIT_REV=0, same preload -> out_r=k, out_i=-k; out_last only at k=2047.
REQ-036 out_ready random 50% -> identical sequence as REQ-034, outputs stable during stalls, never more than 2 outstanding reads+buffered.
REQ-037 out_ready low for 20 cycles after first valid -> mem_rd_en stops after buffer full, sample k=0 held; resumes without loss.
REQ-038 start pulses at k=100 -> ignored, stream unaffected; rst asserted at k=500 -> all outputs 0 immediately, no done; restart yields k=0 first.
REQ-039 Extreme values mem=+(2^40-1) and -2^40 -> passed bit-exact on out_r/out_i.
